udp_rx_cmd_parser: RTL and testbench
====================================

# udp_rx_cmd_parser

Receive-side counterpart of the key-driven UDP test transmitter. It takes the byte stream delivered by the UDP stack's application RX interface and recognises the two-packet sequence: a 2-byte mode command (0x00, 0x02), then one data packet. It reassembles the 3-byte LED pattern or 5-byte segment pattern and presents it as registered outputs with a one-cycle commit strobe. It sits between the UDP stack RX port and the LED/seven-segment display drivers.

## Interface
- ARM_TIMEOUT, 1_000_000, cycles a received mode command stays armed waiting for its data packet (8 ms @125 MHz)
- clk  in  1  system clock, 125 MHz
- rst  in  1  synchronous reset, active-high
- app_rx_data_valid  in  1  high for every byte of a packet; a packet ends when it deasserts
- app_rx_data  in  8  payload byte, sampled when valid
- app_rx_data_length  in  16  UDP payload length, stable during the packet, sampled with the first byte
- led_data  out  24  last committed LED pattern, first received byte in [7:0]
- seg_data  out  40  last committed segment pattern, first received byte in [7:0]
- led_data_valid  out  1  one-cycle strobe on LED commit
- seg_data_valid  out  1  one-cycle strobe on segment commit
- mode  out  1  0 = LED last committed, 1 = segment last committed
- armed  out  1  mode command received, data packet pending
- err_cnt  out  8  saturating count of dropped packets (see Configuration)

## Operation
- States:
  - IDLE: waits for the first valid byte.
  - RX_CMD: packet started while disarmed.
  - RX_DATA: packet started while armed.
  - DROP: consuming a bad packet.
- Capture rules:
  - At the first byte, latch app_rx_data_length.
  - Byte counter starts at 1 on the first byte and increments per valid byte, saturating at 8.
  - Bytes are shifted into a 40-bit capture register at offset (count-1)*8 for counts 1–5.
- End of packet: the first cycle with valid low after any valid byte.
- Command packet:
  - Exactly 2 bytes, length field = 2, bytes 0x00 then 0x02.
  - Sets armed and loads the timeout counter.
  - Accepted in both RX_CMD and RX_DATA; a command received while armed re-arms and restarts the timeout.
- Data packet, received while armed:
  - 3 bytes with length field 3: led_data <= capture[23:0], led_data_valid pulses, mode <= 0.
  - 5 bytes with length field 5: seg_data <= capture[39:0], seg_data_valid pulses, mode <= 1.
  - Either commit clears armed.
- Drop conditions: data packet while disarmed, byte count ≠ latched length, unknown length, or wrong command bytes.
  - The packet is dropped: outputs unchanged, err_cnt +1 (saturates at 255).
  - A bad packet received while armed also clears armed.
- Timeout: while armed and in IDLE, the counter decrements; reaching 0 clears armed without counting an error. The counter is frozen while a packet is in progress.
- A byte count above 5 forces DROP; the capture register is not written beyond byte 5.

## Timing
- Reset values:
  - Outputs: led_data = 0, seg_data = 0, led_data_valid = seg_data_valid = 0, mode = 0, armed = 0, err_cnt = 0.
  - State = IDLE.
- Commit latency: data, strobe, mode and armed update on the first clock edge where valid is sampled low after the packet. They are visible one cycle after the last byte's cycle.
- Strobes are high for exactly one cycle.
- A single valid-low cycle between packets is sufficient.
- Reset asserted mid-packet: return to IDLE with reset values. The remaining bytes of that packet arrive while not armed and are treated as a new packet.
- armed rises 1 cycle after the command packet ends and falls ARM_TIMEOUT cycles later if no packet arrives.

## Configuration
- UDP_RX_ERR_CNT_EN defined: err_cnt is implemented as described.
- UDP_RX_ERR_CNT_EN undefined: err_cnt is tied to 0 and no counter logic is generated. Drop behaviour is otherwise identical.

## Structure
- Shared package udp_app_pkg:
  - Command bytes CMD_B0 = 8'h00, CMD_B1 = 8'h02.
  - LED_LEN = 3, SEG_LEN = 5, CMD_LEN = 2.
  - State enum.
  - The same constants are reused by the transmitter.
- One sub-module, udp_rx_arm_timer: load/decrement/expire counter sized by $clog2(ARM_TIMEOUT+1).

## Test plan
- Cmd {00,02}, then 3-byte packet {AF,0F,F0} → led_data = 24'hF00FAF, led_data_valid one cycle, mode = 0, armed = 0.
- Cmd, then 5-byte packet {00,87,65,43,21} → seg_data = 40'h2143658700, seg_data_valid pulse, mode = 1.
- 3-byte packet with no prior cmd → no strobe, led_data unchanged, err_cnt = 1.
- Cmd, idle ARM_TIMEOUT+1 cycles, then 3-byte packet → armed drops at timeout, packet dropped, err_cnt = 1.
- Cmd {00,03}, or cmd then a 4-byte packet with length 4 → dropped, err_cnt increments, armed = 0.
- Cmd, then rst pulsed during byte 2 of a 5-byte packet → all outputs return to reset values, no strobe.

Source files
------------

// File: rtl/udp_rx_cmd_parser_pkg.sv
// udp_app_pkg: command bytes, packet lengths and parser states shared by the UDP app RX/TX blocks.
package udp_app_pkg;
    localparam logic [7:0] CMD_B0 = 8'h00;
    localparam logic [7:0] CMD_B1 = 8'h02;
    localparam logic [15:0] CMD_LEN = 16'd2;
    localparam logic [15:0] LED_LEN = 16'd3;
    localparam logic [15:0] SEG_LEN = 16'd5;
    typedef enum logic [1:0] {IDLE, RX_CMD, RX_DATA, DROP} state_e;
endpackage

// File: rtl/udp_rx_cmd_parser_arm_timer.sv
// udp_rx_arm_timer: loadable down-counter; expire_o flags the decrement that reaches zero.
module udp_rx_arm_timer #(
    parameter int ARM_TIMEOUT = 1_000_000,
    localparam int W = $clog2(ARM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);
    logic [W-1:0] cnt_q;
    assign expire_o = dec_i && cnt_q == W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= W'(ARM_TIMEOUT);
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
endmodule

// File: rtl/udp_rx_cmd_parser.sv
// udp_rx_cmd_parser: recognises a mode command followed by a 3-byte LED or 5-byte segment packet.
// Define UDP_RX_ERR_CNT_EN to build the saturating dropped-packet counter on err_cnt.
module udp_rx_cmd_parser
    import udp_app_pkg::*;
#(
    parameter int ARM_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        app_rx_data_valid,
    input  logic [7:0]  app_rx_data,
    input  logic [15:0] app_rx_data_length,
    output logic [23:0] led_data,
    output logic [39:0] seg_data,
    output logic        led_data_valid,
    output logic        seg_data_valid,
    output logic        mode,
    output logic        armed,
    output logic [7:0]  err_cnt
);
    state_e      state_q;
    logic [15:0] len_q;
    logic [3:0]  cnt_q;
    logic [39:0] cap_q;
    logic [23:0] led_q;
    logic [39:0] seg_q;
    logic        led_v_q, seg_v_q, mode_q, armed_q;
    logic        eop, is_cmd, is_led, is_seg, tmr_dec, tmr_exp;

    assign eop     = state_q != IDLE && !app_rx_data_valid;
    assign is_cmd  = cnt_q == CMD_LEN[3:0] && len_q == CMD_LEN && cap_q[7:0] == CMD_B0 && cap_q[15:8] == CMD_B1;
    assign is_led  = state_q == RX_DATA && cnt_q == LED_LEN[3:0] && len_q == LED_LEN;
    assign is_seg  = state_q == RX_DATA && cnt_q == SEG_LEN[3:0] && len_q == SEG_LEN;
    assign tmr_dec = armed_q && state_q == IDLE && !app_rx_data_valid;

    udp_rx_arm_timer #(.ARM_TIMEOUT(ARM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (eop && is_cmd),
        .dec_i    (tmr_dec),
        .expire_o (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            led_q   <= '0;
            seg_q   <= '0;
            led_v_q <= 1'b0;
            seg_v_q <= 1'b0;
            mode_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            led_v_q <= 1'b0;
            seg_v_q <= 1'b0;
            if (tmr_exp) armed_q <= 1'b0;
            if (state_q == IDLE) begin
                if (app_rx_data_valid) begin
                    state_q    <= armed_q ? RX_DATA : RX_CMD;
                    len_q      <= app_rx_data_length;
                    cnt_q      <= 4'd1;
                    cap_q[7:0] <= app_rx_data;
                end
            end else if (app_rx_data_valid) begin
                cnt_q <= cnt_q == 4'd8 ? cnt_q : cnt_q + 4'd1;
                // cnt_q is the count before this byte, so it doubles as the byte's slot index
                if (cnt_q < 4'd5) cap_q[{cnt_q[2:0], 3'b000} +: 8] <= app_rx_data;
                else state_q <= DROP;
            end else begin
                state_q <= IDLE;
                armed_q <= is_cmd;
                if (is_led) begin
                    led_q   <= cap_q[23:0];
                    led_v_q <= 1'b1;
                    mode_q  <= 1'b0;
                end
                if (is_seg) begin
                    seg_q   <= cap_q;
                    seg_v_q <= 1'b1;
                    mode_q  <= 1'b1;
                end
            end
        end
    end

`ifdef UDP_RX_ERR_CNT_EN
    logic [7:0] err_q;
    logic       drop;
    assign drop = eop && !(is_cmd || is_led || is_seg);
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else if (drop && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign led_data       = led_q;
    assign seg_data       = seg_q;
    assign led_data_valid = led_v_q;
    assign seg_data_valid = seg_v_q;
    assign mode           = mode_q;
    assign armed          = armed_q;
endmodule

// File: tb/tb_udp_rx_cmd_parser.sv
// tb_udp_rx_cmd_parser: directed packet table, corner sequences and random traffic against a packet-level model.
module tb_udp_rx_cmd_parser;
    localparam int T = 20;
`ifdef UDP_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, v;
    logic [7:0]  d;
    logic [15:0] l;
    logic [23:0] led_data;
    logic [39:0] seg_data;
    logic        led_data_valid, seg_data_valid, mode, armed;
    logic [7:0]  err_cnt;

    udp_rx_cmd_parser #(.ARM_TIMEOUT(T)) dut (
        .clk                (clk),
        .rst                (rst),
        .app_rx_data_valid  (v),
        .app_rx_data        (d),
        .app_rx_data_length (l),
        .led_data           (led_data),
        .seg_data           (seg_data),
        .led_data_valid     (led_data_valid),
        .seg_data_valid     (seg_data_valid),
        .mode               (mode),
        .armed              (armed),
        .err_cnt            (err_cnt)
    );

    always #4 clk = ~clk;

    int vectors = 0, miscompares = 0;

    logic [23:0] m_led;
    logic [39:0] m_seg;
    logic        m_lv, m_sv, m_mode, m_armed, in_pkt;
    int          m_left, m_err;
    logic [15:0] m_len;
    logic [7:0]  q[$];

    function automatic logic [7:0] e(input int x);
        return ERR_EN ? 8'(x) : 8'd0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic vv, input logic [7:0] dd, input logic [15:0] ll);
        rst = r; v = vv; d = dd; l = ll;
        @(posedge clk);
        m_lv = 1'b0;
        m_sv = 1'b0;
        if (r) begin
            m_armed = 0; m_left = 0; m_led = '0; m_seg = '0; m_mode = 0; m_err = 0; in_pkt = 0;
            q.delete();
        end else if (vv) begin
            if (!in_pkt) begin
                in_pkt = 1;
                m_len = ll;
                q.delete();
            end
            q.push_back(dd);
        end else if (in_pkt) begin
            in_pkt = 0;
            if (q.size() == 2 && m_len == 2 && q[0] == 8'h00 && q[1] == 8'h02) begin
                m_armed = 1;
                m_left = T;
            end else if (m_armed && q.size() == 3 && m_len == 3) begin
                m_led = {q[2], q[1], q[0]}; m_lv = 1; m_mode = 0; m_armed = 0;
            end else if (m_armed && q.size() == 5 && m_len == 5) begin
                m_seg = {q[4], q[3], q[2], q[1], q[0]}; m_sv = 1; m_mode = 1; m_armed = 0;
            end else begin
                if (m_err < 255) m_err++;
                m_armed = 0;
            end
        end else if (m_armed) begin
            m_left--;
            if (m_left == 0) m_armed = 0;
        end
        #1;
        vectors++;
        if ({led_data, seg_data, led_data_valid, seg_data_valid, mode, armed, err_cnt} !==
            {m_led, m_seg, m_lv, m_sv, m_mode, m_armed, e(m_err)}) begin
            miscompares++;
            $display("FAIL model: got led=%h seg=%h lv=%b sv=%b mode=%b armed=%b err=%0d, expected led=%h seg=%h lv=%b sv=%b mode=%b armed=%b err=%0d",
                     led_data, seg_data, led_data_valid, seg_data_valid, mode, armed, err_cnt,
                     m_led, m_seg, m_lv, m_sv, m_mode, m_armed, e(m_err));
        end
    endtask

    task automatic send(input int n, input logic [63:0] b, input logic [15:0] len);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, b[i*8 +: 8], len);
        step(1'b0, 1'b0, 8'h00, 16'h0);
    endtask

    typedef struct {
        int          n;
        logic [63:0] b;
        logic [15:0] len;
        logic [23:0] led;
        logic [39:0] seg;
        logic        lv, sv, md, arm;
        int          err;
    } row_t;

    localparam logic [39:0] S = 40'h2143658700;
    row_t rows[16];

    initial begin
        rows = '{
            '{2, 64'h0200,           16'd2, 24'h0,      40'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
            '{3, 64'hF00FAF,         16'd3, 24'hF00FAF, 40'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, 40'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
            '{5, 64'h2143658700,     16'd5, 24'hF00FAF, S,     1'b0, 1'b1, 1'b1, 1'b0, 0},
            '{3, 64'hF00FAF,         16'd3, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b0, 1},
            '{2, 64'h0300,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b0, 2},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b1, 2},
            '{4, 64'h04030201,       16'd4, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b0, 3},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b1, 3},
            '{3, 64'h332211,         16'd5, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b0, 4},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b1, 4},
            '{7, 64'h77665544332211, 16'd7, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b0, 5},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b1, 5},
            '{2, 64'h0200,           16'd2, 24'hF00FAF, S,     1'b0, 1'b0, 1'b1, 1'b1, 5},
            '{3, 64'h332211,         16'd3, 24'h332211, S,     1'b1, 1'b0, 1'b0, 1'b0, 5},
            '{2, 64'h0200,           16'd3, 24'h332211, S,     1'b0, 1'b0, 1'b0, 1'b0, 6}
        };

        step(1'b1, 1'b0, 8'h00, 16'h0);
        step(1'b1, 1'b0, 8'h00, 16'h0);
        chk("reset outputs", {led_data, seg_data, led_data_valid, seg_data_valid, mode, armed, err_cnt}, 64'h0);
        chk("reset led", led_data, 24'h0);

        for (int i = 0; i < 16; i++) begin
            send(rows[i].n, rows[i].b, rows[i].len);
            chk($sformatf("row%0d led", i), led_data, rows[i].led);
            chk($sformatf("row%0d seg", i), seg_data, rows[i].seg);
            chk($sformatf("row%0d strobes", i), {led_data_valid, seg_data_valid}, {rows[i].lv, rows[i].sv});
            chk($sformatf("row%0d mode/armed", i), {mode, armed}, {rows[i].md, rows[i].arm});
            chk($sformatf("row%0d err", i), err_cnt, e(rows[i].err));
            step(1'b0, 1'b0, 8'h00, 16'h0);
            chk($sformatf("row%0d strobe width", i), {led_data_valid, seg_data_valid}, 2'b00);
        end

        send(2, 64'h0200, 16'd2);
        for (int i = 0; i < T - 1; i++) step(1'b0, 1'b0, 8'h00, 16'h0);
        chk("armed before timeout", armed, 1'b1);
        step(1'b0, 1'b0, 8'h00, 16'h0);
        chk("armed at timeout", armed, 1'b0);
        send(3, 64'h998877, 16'd3);
        chk("post-timeout led", {led_data, led_data_valid}, {24'h332211, 1'b0});
        chk("post-timeout err", err_cnt, e(7));

        send(2, 64'h0200, 16'd2);
        step(1'b0, 1'b1, 8'h00, 16'd5);
        step(1'b1, 1'b1, 8'h87, 16'd5);
        chk("mid-packet reset", {led_data, seg_data, led_data_valid, seg_data_valid, mode, armed, err_cnt}, 64'h0);
        step(1'b0, 1'b1, 8'h65, 16'd5);
        step(1'b0, 1'b1, 8'h43, 16'd5);
        step(1'b0, 1'b1, 8'h21, 16'd5);
        step(1'b0, 1'b0, 8'h00, 16'h0);
        chk("tail after reset", {seg_data, seg_data_valid, armed, err_cnt}, {40'h0, 1'b0, 1'b0, e(1)});

        for (int i = 0; i < 260; i++) send(1, 64'h55, 16'd1);
        chk("err saturation", err_cnt, e(255));
        step(1'b1, 1'b0, 8'h00, 16'h0);

        for (int p = 0; p < 400; p++) begin
            int          n, k;
            logic [63:0] b;
            logic [15:0] len;
            b = {$urandom, $urandom};
            k = int'($urandom_range(0, 5));
            if (k == 0 || k == 4) begin n = 2; b[15:0] = 16'h0200; len = 16'd2; end
            else if (k == 1) begin n = 3; len = 16'd3; end
            else if (k == 2) begin n = 5; len = 16'd5; end
            else if (k == 3) begin n = int'($urandom_range(1, 7)); len = ($urandom % 2) ? 16'(n) : 16'($urandom_range(0, 8)); end
            else begin n = 2; b[15:0] = 16'($urandom_range(0, 3)) << 8; len = 16'($urandom_range(1, 3)); end
            for (int i = 0; i < n; i++) step(($urandom % 100) == 0, 1'b1, b[i*8 +: 8], len);
            step(1'b0, 1'b0, 8'h00, 16'h0);
            for (int g = ($urandom % 4 == 0) ? int'($urandom_range(0, T + 3)) : 0; g > 0; g--)
                step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
